// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor slice: counter constants for a
// given counter width, the saturating counter step, and the index/tag
// extraction helpers used on both the fetch and the resolve side.
// Counters are carried at the widest supported width (3 bits) inside these
// helpers; callers narrow the result back to their own CNT_W.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int MAX_CNT_W = 3;
    localparam int MAX_IDX_W = 10;

    typedef logic [MAX_CNT_W-1:0] cntWide_t;
    typedef logic [MAX_IDX_W-1:0] idxWide_t;

    // Strongly-taken saturation ceiling, 2^cntW - 1
    function automatic cntWide_t cnt_max(input int cntW);
        return cntWide_t'((1 << cntW) - 1);
    endfunction

    // Weakly-taken, the value a freshly allocated entry starts at
    function automatic cntWide_t cnt_weak_t(input int cntW);
        return cntWide_t'(1 << (cntW - 1));
    endfunction

    // Weakly-not-taken, the reset value; collapses to 0 for 1-bit counters
    function automatic cntWide_t cnt_weak_nt(input int cntW);
        return cntWide_t'((1 << (cntW - 1)) - 1);
    endfunction

    // One saturating step towards taken or not-taken
    function automatic cntWide_t sat_update(input cntWide_t cnt, input logic taken,
                                            input cntWide_t cntMax);
        cntWide_t result;
        result = cnt;
        if (taken) begin
            if (cnt != cntMax) result = cnt + cntWide_t'(1);
        end else begin
            if (cnt != '0) result = cnt - cntWide_t'(1);
        end
        return result;
    endfunction

    // Word-aligned PC bits XORed with the zero-extended global history;
    // bimodal callers simply pass an all-zero history
    function automatic idxWide_t bp_index(input logic [31:0] pc, input idxWide_t ghr,
                                          input int idxW);
        logic [31:0] mask;
        mask = (32'd1 << idxW) - 32'd1;
        return idxWide_t'((pc >> 2) & mask) ^ ghr;
    endfunction

    // PC bits directly above the index field; callers truncate to TAG_W
    function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idxW);
        return pc >> (idxW + 2);
    endfunction

endpackage

// File: rtl/bp_table.sv
// ---------------------------------------------------------------------------
// bp_table
// Direct-mapped predictor storage: valid bit, tag, target and saturating
// counter per entry, all held in flops so a reset can clear every entry.
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   rdIdx_i          combinational lookup index
//   rdValid_o        entry valid at rdIdx_i
//   rdTag_o          stored tag at rdIdx_i
//   rdTarget_o       stored target at rdIdx_i
//   rdCntMsb_o       counter MSB (taken/not-taken decision) at rdIdx_i
//   wrValid_i        a branch resolves this cycle
//   wrIdx_i          index captured at fetch for the resolving branch
//   wrTag_i          tag of the resolving branch
//   wrTaken_i        actual outcome
//   wrTarget_i       actual taken target
// ---------------------------------------------------------------------------
module bp_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rdIdx_i,
    output logic             rdValid_o,
    output logic [TAG_W-1:0] rdTag_o,
    output logic [31:0]      rdTarget_o,
    output logic             rdCntMsb_o,
    input  logic             wrValid_i,
    input  logic [IDX_W-1:0] wrIdx_i,
    input  logic [TAG_W-1:0] wrTag_i,
    input  logic             wrTaken_i,
    input  logic [31:0]      wrTarget_i
);

    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));

    logic             validQ  [ENTRIES];
    logic [TAG_W-1:0] tagQ    [ENTRIES];
    logic [31:0]      targetQ [ENTRIES];
    logic [CNT_W-1:0] cntQ    [ENTRIES];

    logic             wrHit;
    logic             wrEnD;
    logic [CNT_W-1:0] wrCntD;
    logic [31:0]      wrTargetD;

    // Lookup reads the registered arrays only, so an entry written this
    // cycle is seen by fetch from the following cycle on
    always_comb begin
        rdValid_o  = validQ[rdIdx_i];
        rdTag_o    = tagQ[rdIdx_i];
        rdTarget_o = targetQ[rdIdx_i];
        rdCntMsb_o = cntQ[rdIdx_i][CNT_W-1];
    end

    // Decide what the resolving branch does to its entry: train on a tag
    // hit, allocate on a taken miss, and leave the entry alone on a
    // not-taken miss so a cold branch cannot evict a trained one
    always_comb begin
        wrHit     = validQ[wrIdx_i] && (tagQ[wrIdx_i] == wrTag_i);
        wrEnD     = 1'b0;
        wrCntD    = cntQ[wrIdx_i];
        wrTargetD = targetQ[wrIdx_i];
        if (wrValid_i) begin
            if (wrHit) begin
                wrEnD  = 1'b1;
                wrCntD = CNT_W'(sat_update(cntWide_t'(cntQ[wrIdx_i]), wrTaken_i,
                                           cntWide_t'(CNT_MAX)));
                if (wrTaken_i) wrTargetD = wrTarget_i;
            end else if (wrTaken_i) begin
                wrEnD     = 1'b1;
                wrCntD    = CNT_WEAK_T;
                wrTargetD = wrTarget_i;
            end
        end
    end

    // Entry storage; reset wins over a concurrent write and also clears
    // tag/target so the fetch target output is deterministic after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                cntQ[i]    <= CNT_WEAK_NT;
            end
        end else if (wrEnD) begin
            validQ[wrIdx_i]  <= 1'b1;
            tagQ[wrIdx_i]    <= wrTag_i;
            targetQ[wrIdx_i] <= wrTargetD;
            cntQ[wrIdx_i]    <= wrCntD;
        end
    end

endmodule

// File: rtl/branch_predictor_2bit.sv
// ---------------------------------------------------------------------------
// branch_predictor_2bit
// Branch target buffer with N-bit saturating counters and optional gshare
// indexing. Fetch lookup is combinational; training happens when a branch
// resolves in EX, using the index that travelled down with the instruction.
// Ports:
//   clk, rst       core clock, synchronous active-high reset
//   PCF            fetch PC
//   PredTakenF     predict taken for PCF
//   PredTargetF    predicted target for PCF
//   PredIndexF     table index used for PCF (pipelined to EX as PredIndexE)
//   UpdateValidE   a conditional branch resolves in EX this cycle
//   PCE            PC of the resolving branch
//   PredIndexE     index captured at fetch
//   PredTakenE     prediction made at fetch
//   PredTargetE    target predicted at fetch
//   BrTakenE       actual outcome
//   BrTargetE      actual taken target
//   MispredictE    redirect request for the fetch unit / hazard unit
//   BranchCount    resolved-branch count, wraps modulo 2^32
//   MispredCount   mispredict count, wraps modulo 2^32
// ---------------------------------------------------------------------------
module branch_predictor_2bit
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int HIST_W  = 0,
    parameter int CNT_W   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 PCF,
    output logic                        PredTakenF,
    output logic [31:0]                 PredTargetF,
    output logic [$clog2(ENTRIES)-1:0]  PredIndexF,
    input  logic                        UpdateValidE,
    input  logic [31:0]                 PCE,
    input  logic [$clog2(ENTRIES)-1:0]  PredIndexE,
    input  logic                        PredTakenE,
    input  logic [31:0]                 PredTargetE,
    input  logic                        BrTakenE,
    input  logic [31:0]                 BrTargetE,
    output logic                        MispredictE,
    output logic [31:0]                 BranchCount,
    output logic [31:0]                 MispredCount
);

    localparam int IDX_W = $clog2(ENTRIES);

    if (ENTRIES < 4 || ENTRIES > 1024 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_badEntries
        $error("branch_predictor_2bit: ENTRIES must be a power of 2 in 4..1024");
    end
    if (HIST_W < 0 || HIST_W > IDX_W) begin : g_badHist
        $error("branch_predictor_2bit: HIST_W must be in 0..IDX_W");
    end
    if (CNT_W < 1 || CNT_W > 3) begin : g_badCnt
        $error("branch_predictor_2bit: CNT_W must be in 1..3");
    end
    if (TAG_W < 1 || IDX_W + 2 + TAG_W > 32) begin : g_badTag
        $error("branch_predictor_2bit: tag field must fit inside the PC");
    end

    idxWide_t         ghrExt;
    logic [IDX_W-1:0] idxF;
    logic [TAG_W-1:0] tagF;
    logic [TAG_W-1:0] tagE;
    logic             rdValid;
    logic [TAG_W-1:0] rdTag;
    logic [31:0]      rdTarget;
    logic             rdCntMsb;
    logic [31:0]      branchCountQ, branchCountD;
    logic [31:0]      mispredCountQ, mispredCountD;

    // Global history only exists in gshare builds; it shifts in each
    // resolved outcome, never a speculative one
    if (HIST_W > 0) begin : g_ghr
        logic [HIST_W-1:0] ghrQ, ghrD;

        // Next history: oldest outcome falls off the top
        always_comb begin
            ghrD = ghrQ;
            if (UpdateValidE) ghrD = HIST_W'({ghrQ, BrTakenE});
        end

        // History register
        always_ff @(posedge clk) begin
            if (rst) ghrQ <= '0;
            else     ghrQ <= ghrD;
        end

        assign ghrExt = idxWide_t'(ghrQ);
    end else begin : g_noGhr
        assign ghrExt = '0;
    end

    assign idxF = IDX_W'(bp_index(PCF, ghrExt, IDX_W));
    assign tagF = TAG_W'(bp_tag(PCF, IDX_W));
    assign tagE = TAG_W'(bp_tag(PCE, IDX_W));

    bp_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .rdIdx_i    (idxF),
        .rdValid_o  (rdValid),
        .rdTag_o    (rdTag),
        .rdTarget_o (rdTarget),
        .rdCntMsb_o (rdCntMsb),
        .wrValid_i  (UpdateValidE),
        .wrIdx_i    (PredIndexE),
        .wrTag_i    (tagE),
        .wrTaken_i  (BrTakenE),
        .wrTarget_i (BrTargetE)
    );

    // Fetch-side prediction; the target is passed through even on a miss
    // because consumers only use it when PredTakenF is set
    always_comb begin
        PredIndexF  = idxF;
        PredTakenF  = rdValid && (rdTag == tagF) && rdCntMsb;
        PredTargetF = rdTarget;
    end

    // A resolved branch was mispredicted if the direction was wrong, or it
    // was taken somewhere other than the predicted target
    always_comb begin
        MispredictE = UpdateValidE &&
                      ((PredTakenE != BrTakenE) || (BrTakenE && (PredTargetE != BrTargetE)));
    end

    // Statistics next-state; both counters wrap naturally at 32 bits
    always_comb begin
        branchCountD  = branchCountQ;
        mispredCountD = mispredCountQ;
        if (UpdateValidE) begin
            branchCountD  = branchCountQ + 32'd1;
            mispredCountD = mispredCountQ + {31'd0, MispredictE};
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            branchCountQ  <= '0;
            mispredCountQ <= '0;
        end else begin
            branchCountQ  <= branchCountD;
            mispredCountQ <= mispredCountD;
        end
    end

    assign BranchCount  = branchCountQ;
    assign MispredCount = mispredCountQ;

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_2bit
// Drives a bimodal instance and a gshare (HIST_W=4) instance with the same
// branch stream. Each branch is fetched in one cycle and resolved in the
// next, so lookups and updates to the same index overlap. A behavioural
// model predicts every output; expectations are queued when a cycle is
// driven and compared once the outputs have settled.
// ---------------------------------------------------------------------------
module tb_branch_predictor_2bit;

    logic clk = 1'b0;
    logic rst;

    // Free-running core clock
    always #5 clk = ~clk;

    logic [31:0] PCF, PCE, BrTargetE;
    logic        UpdateValidE, BrTakenE;
    logic [5:0]  predIdxE   [2];
    logic        predTakenE [2];
    logic [31:0] predTgtE   [2];
    logic        takenF     [2];
    logic [31:0] targetF    [2];
    logic [5:0]  indexF     [2];
    logic        mispredE   [2];
    logic [31:0] brCnt      [2];
    logic [31:0] misCnt     [2];

    branch_predictor_2bit #(.ENTRIES(64), .TAG_W(8), .HIST_W(0), .CNT_W(2)) dutBimodal (
        .clk(clk), .rst(rst), .PCF(PCF),
        .PredTakenF(takenF[0]), .PredTargetF(targetF[0]), .PredIndexF(indexF[0]),
        .UpdateValidE(UpdateValidE), .PCE(PCE), .PredIndexE(predIdxE[0]),
        .PredTakenE(predTakenE[0]), .PredTargetE(predTgtE[0]),
        .BrTakenE(BrTakenE), .BrTargetE(BrTargetE), .MispredictE(mispredE[0]),
        .BranchCount(brCnt[0]), .MispredCount(misCnt[0])
    );

    branch_predictor_2bit #(.ENTRIES(64), .TAG_W(8), .HIST_W(4), .CNT_W(2)) dutGshare (
        .clk(clk), .rst(rst), .PCF(PCF),
        .PredTakenF(takenF[1]), .PredTargetF(targetF[1]), .PredIndexF(indexF[1]),
        .UpdateValidE(UpdateValidE), .PCE(PCE), .PredIndexE(predIdxE[1]),
        .PredTakenE(predTakenE[1]), .PredTargetE(predTgtE[1]),
        .BrTakenE(BrTakenE), .BrTargetE(BrTargetE), .MispredictE(mispredE[1]),
        .BranchCount(brCnt[1]), .MispredCount(misCnt[1])
    );

    int vectorCount = 0;
    int missCount   = 0;

    typedef struct {
        int          k;
        logic        taken;
        logic [31:0] target;
        logic [5:0]  index;
        logic        mis;
        logic [31:0] brCnt;
        logic [31:0] misCnt;
    } expect_t;

    expect_t scoreboard[$];

    // Reference model state, one copy per instance (0 bimodal, 1 gshare)
    logic        mValid  [2][64];
    logic [7:0]  mTag    [2][64];
    logic [31:0] mTarget [2][64];
    logic [1:0]  mCnt    [2][64];
    logic [3:0]  mGhr    [2];
    logic [31:0] mBrCnt  [2];
    logic [31:0] mMisCnt [2];

    // Branch fetched last cycle, resolving in the current one
    logic        pendValid;
    logic [31:0] pendPc, pendTgt;
    logic        pendTaken;
    logic [5:0]  pendIdx       [2];
    logic        pendPredTaken [2];
    logic [31:0] pendPredTgt   [2];

    // Outputs as sampled on the latest compare, for directed checks
    logic        lastTaken  [2];
    logic [31:0] lastTarget [2];
    logic        lastMis    [2];
    logic [31:0] lastBrCnt  [2];
    logic [31:0] lastMisCnt [2];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [5:0] modelIndex(input int k, input logic [31:0] pc);
        logic [5:0] base;
        base = pc[7:2];
        if (k == 1) base = base ^ {2'b00, mGhr[1]};
        return base;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                mValid[k][i]  = 1'b0;
                mTag[k][i]    = 8'h00;
                mTarget[k][i] = 32'h0;
                mCnt[k][i]    = 2'd1;
            end
            mGhr[k]    = 4'h0;
            mBrCnt[k]  = 32'd0;
            mMisCnt[k] = 32'd0;
        end
    endtask

    task automatic modelUpdate(input int k, input logic [5:0] idx, input logic [31:0] pc,
                               input logic taken, input logic [31:0] tgt, input logic mis);
        if (mValid[k][idx] && mTag[k][idx] == pc[15:8]) begin
            if (taken) begin
                if (mCnt[k][idx] != 2'd3) mCnt[k][idx] = mCnt[k][idx] + 2'd1;
                mTarget[k][idx] = tgt;
            end else if (mCnt[k][idx] != 2'd0) begin
                mCnt[k][idx] = mCnt[k][idx] - 2'd1;
            end
        end else if (taken) begin
            mValid[k][idx]  = 1'b1;
            mTag[k][idx]    = pc[15:8];
            mTarget[k][idx] = tgt;
            mCnt[k][idx]    = 2'd2;
        end
        mGhr[k]    = {mGhr[k][2:0], taken};
        mBrCnt[k]  = mBrCnt[k] + 32'd1;
        mMisCnt[k] = mMisCnt[k] + 32'(mis);
    endtask

    task automatic driveResolve();
        UpdateValidE = pendValid;
        PCE          = pendPc;
        BrTakenE     = pendTaken;
        BrTargetE    = pendTgt;
        for (int k = 0; k < 2; k++) begin
            predIdxE[k]   = pendIdx[k];
            predTakenE[k] = pendPredTaken[k];
            predTgtE[k]   = pendPredTgt[k];
        end
    endtask

    task automatic drainScoreboard();
        expect_t e;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            lastTaken[e.k]  = takenF[e.k];
            lastTarget[e.k] = targetF[e.k];
            lastMis[e.k]    = mispredE[e.k];
            lastBrCnt[e.k]  = brCnt[e.k];
            lastMisCnt[e.k] = misCnt[e.k];
            checkOutput($sformatf("dut%0d.PredTakenF", e.k), 32'(takenF[e.k]), 32'(e.taken));
            checkOutput($sformatf("dut%0d.PredTargetF", e.k), targetF[e.k], e.target);
            checkOutput($sformatf("dut%0d.PredIndexF", e.k), 32'(indexF[e.k]), 32'(e.index));
            checkOutput($sformatf("dut%0d.MispredictE", e.k), 32'(mispredE[e.k]), 32'(e.mis));
            checkOutput($sformatf("dut%0d.BranchCount", e.k), brCnt[e.k], e.brCnt);
            checkOutput($sformatf("dut%0d.MispredCount", e.k), misCnt[e.k], e.misCnt);
        end
    endtask

    // One cycle: fetch pc (optionally recording its outcome for resolution
    // next cycle) while resolving the previously fetched branch
    task automatic applyStimulus(input logic [31:0] pc, input logic fetch,
                                 input logic taken, input logic [31:0] tgt);
        expect_t     e;
        logic [5:0]  idx [2];
        logic        pt  [2];
        logic [31:0] ptg [2];
        logic        mis [2];
        @(negedge clk);
        PCF = pc;
        driveResolve();
        for (int k = 0; k < 2; k++) begin
            idx[k] = modelIndex(k, pc);
            pt[k]  = mValid[k][idx[k]] && (mTag[k][idx[k]] == pc[15:8]) && mCnt[k][idx[k]][1];
            ptg[k] = mTarget[k][idx[k]];
            mis[k] = pendValid && ((pendPredTaken[k] != pendTaken) ||
                                   (pendTaken && (pendPredTgt[k] != pendTgt)));
            e.k      = k;
            e.taken  = pt[k];
            e.target = ptg[k];
            e.index  = idx[k];
            e.mis    = mis[k];
            e.brCnt  = mBrCnt[k];
            e.misCnt = mMisCnt[k];
            scoreboard.push_back(e);
        end
        #1;
        drainScoreboard();
        @(posedge clk);
        if (pendValid) begin
            for (int k = 0; k < 2; k++) modelUpdate(k, pendIdx[k], pendPc, pendTaken, pendTgt, mis[k]);
        end
        pendValid = fetch;
        pendPc    = pc;
        pendTaken = taken;
        pendTgt   = tgt;
        for (int k = 0; k < 2; k++) begin
            pendIdx[k]       = idx[k];
            pendPredTaken[k] = pt[k];
            pendPredTgt[k]   = ptg[k];
        end
    endtask

    // Reset asserted in the same cycle the pending branch resolves
    task automatic resetWithUpdate();
        @(negedge clk);
        driveResolve();
        rst = 1'b1;
        @(posedge clk);
        modelReset();
        pendValid = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        UpdateValidE = 1'b0;
    endtask

    logic [31:0] baseMis, endMis;

    initial begin
        rst          = 1'b1;
        PCF          = 32'h0;
        pendValid    = 1'b0;
        pendPc       = 32'h0;
        pendTaken    = 1'b0;
        pendTgt      = 32'h0;
        for (int k = 0; k < 2; k++) begin
            pendIdx[k]       = 6'd0;
            pendPredTaken[k] = 1'b0;
            pendPredTgt[k]   = 32'h0;
        end
        driveResolve();
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Cold lookup, then train 0x100 taken to 0x80
        applyStimulus(32'h100, 1'b1, 1'b1, 32'h80);
        checkOutput("t1.resetTaken", 32'(lastTaken[0]), 32'h0);
        checkOutput("t1.resetTarget", lastTarget[0], 32'h0);
        applyStimulus(32'h100, 1'b1, 1'b1, 32'h80);
        checkOutput("t1.sameIndexOld", 32'(lastTaken[0]), 32'h0);
        applyStimulus(32'h100, 1'b0, 1'b0, 32'h0);
        checkOutput("t1.trainedTaken", 32'(lastTaken[0]), 32'h1);
        checkOutput("t1.trainedTarget", lastTarget[0], 32'h80);

        // Aliasing: 0x1100 shares the index of 0x100 but not its tag
        applyStimulus(32'h1100, 1'b1, 1'b0, 32'h0);
        checkOutput("t3.aliasMiss", 32'(lastTaken[0]), 32'h0);
        applyStimulus(32'h100, 1'b0, 1'b0, 32'h0);
        applyStimulus(32'h100, 1'b0, 1'b0, 32'h0);
        checkOutput("t3.entryIntact", 32'(lastTaken[0]), 32'h1);
        checkOutput("t3.targetIntact", lastTarget[0], 32'h80);

        // Loop branch: taken x3 then exit, one bubble after each fetch
        for (int it = 0; it < 5; it++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus(32'h200, 1'b1, (j < 3), 32'h180);
                if (j == 0 && it == 3) baseMis = lastMisCnt[0];
                if (j == 0 && it == 4) endMis = lastMisCnt[0];
                applyStimulus(32'h200, 1'b0, 1'b0, 32'h0);
            end
        end
        checkOutput("t2.exitOnlyMispredict", endMis - baseMis, 32'd1);

        // Target change on a strongly-taken entry
        for (int n = 0; n < 3; n++) begin
            applyStimulus(32'h300, 1'b1, 1'b1, 32'h400);
            applyStimulus(32'h300, 1'b0, 1'b0, 32'h0);
        end
        applyStimulus(32'h300, 1'b1, 1'b1, 32'h500);
        checkOutput("t4.predictedOld", lastTarget[0], 32'h400);
        applyStimulus(32'h300, 1'b0, 1'b0, 32'h0);
        checkOutput("t4.targetMispredict", 32'(lastMis[0]), 32'h1);
        applyStimulus(32'h300, 1'b0, 1'b0, 32'h0);
        checkOutput("t4.newTarget", lastTarget[0], 32'h500);

        // Correlated pair for gshare: A alternates T/N, B copies A
        for (int p = 0; p < 6; p++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus(((j % 2) == 0) ? 32'h400 : 32'h404, 1'b1, (j < 2), 32'h600);
                if (j == 0 && p == 4) baseMis = lastMisCnt[1];
                applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
            end
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5.gshareNoMispredict", lastMisCnt[1] - baseMis, 32'd0);

        // Reset in the same cycle as an update discards the update
        applyStimulus(32'h300, 1'b1, 1'b1, 32'h700);
        resetWithUpdate();
        applyStimulus(32'h300, 1'b0, 1'b0, 32'h0);
        checkOutput("t6.branchCountB", lastBrCnt[0], 32'd0);
        checkOutput("t6.branchCountG", lastBrCnt[1], 32'd0);
        checkOutput("t6.mispredCount", lastMisCnt[0], 32'd0);
        checkOutput("t6.takenCleared", 32'(lastTaken[0]), 32'h0);
        checkOutput("t6.targetCleared", lastTarget[0], 32'h0);
        applyStimulus(32'h300, 1'b1, 1'b1, 32'h800);
        applyStimulus(32'h300, 1'b0, 1'b0, 32'h0);
        applyStimulus(32'h300, 1'b0, 1'b0, 32'h0);
        checkOutput("t6.reallocTaken", 32'(lastTaken[0]), 32'h1);
        checkOutput("t6.reallocTarget", lastTarget[0], 32'h800);
        checkOutput("t6.branchCountAfter", lastBrCnt[0], 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
